// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
// Holds the default width, counter sizing and the FSM state encoding.
package serial_arith_pkg;

  localparam int SERIAL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ser_state_t;

  // Bit counter spans 0..WIDTH-1; keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts a, b, bin, resolves one bit per cycle LSB first,
// and presents diff/bout/zero/ovf with a valid/ready handshake on both sides.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-2:0] r_dsr;
  logic             r_br, r_a_sign, r_b_sign;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid, r_bout, r_zero, r_ovf;
  logic [WIDTH-1:0] r_diff;

  logic             w_d, w_br_nxt, w_accept, w_last, w_handoff;
  logic [WIDTH-1:0] w_diff_fin;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br_nxt)
  );

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_last     = (r_state == ST_SHIFT) && (r_cnt == LAST);
  assign w_handoff  = (r_state == ST_DONE) && out_ready;
  // Bits resolved so far sit in r_dsr; the bit being resolved lands on top.
  assign w_diff_fin = {w_d, r_dsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_dsr       <= '0;
      r_br        <= 1'b0;
      r_a_sign    <= 1'b0;
      r_b_sign    <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_br     <= bin;
        r_a_sign <= a[WIDTH-1];
        r_b_sign <= b[WIDTH-1];
        r_dsr    <= '0;
        r_cnt    <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_nxt;
        r_dsr <= w_diff_fin[WIDTH-1:1];
        r_cnt <= r_cnt + 1'b1;
      end

      // Result registers only change on completion, so they survive handoff.
      if (w_last) begin
        r_diff      <= w_diff_fin;
        r_bout      <= w_br_nxt;
        r_zero      <= (w_diff_fin == '0);
        r_ovf       <= (r_a_sign ^ r_b_sign) & (r_a_sign ^ w_d);
        r_out_valid <= 1'b1;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and randomized bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid, out_ready;
  logic [W-1:0] diff;
  logic         bout, zero, ovf;

  int n_chk  = 0;
  int n_fail = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo, z, ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge, then scramble them.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] ed, input logic eb,
                           input logic ez, input logic eo);
    chk({tag, "_diff"}, {24'b0, diff}, {24'b0, ed});
    chk({tag, "_bout"}, {31'b0, bout}, {31'b0, eb});
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
    chk({tag, "_ovf"},  {31'b0, ovf},  {31'b0, eo});
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_out_valid", {31'b0, out_valid}, 32'd0);
    chk("handoff_in_ready",  {31'b0, in_ready},  32'd1);
  endtask

  initial begin
    int lat, guard;
    logic [W-1:0] ra, rb, rd;
    logic         rbin, rbo, rov;
    logic [W:0]   wide;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Directed vectors, each with exact latency check.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
      wait_result(lat);
      chk("vec_latency", lat, 32'd8);
      check_res($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].z, vecs[i].ov);
      handoff();
    end

    // Backpressure: stalled result must hold while new operands are ignored.
    start_op(8'h05, 8'h03, 1'b0);
    wait_result(lat);
    chk("bp_latency", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid | (i == 0);
      a = 8'hFF; b = 8'h01; bin = 1'b1;
      tick();
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
      check_res("bp", 8'h02, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    handoff();
    chk("bp_diff_retained", {24'b0, diff}, 32'h02);
    repeat (3) tick();
    chk("bp_no_queued_op", {31'b0, out_valid}, 32'd0);
    chk("bp_still_idle",   {31'b0, in_ready},  32'd1);

    // Reset during the 4th shift cycle discards the operation.
    start_op(8'h80, 8'h01, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check_res("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("postrst_out_valid", {31'b0, out_valid}, 32'd0);
    start_op(8'h05, 8'h03, 1'b0);
    wait_result(lat);
    chk("postrst_latency", lat, 32'd8);
    check_res("postrst", 8'h02, 1'b0, 1'b0, 1'b0);
    handoff();

    // Random back-to-back ops with random consumer stalls and ignored input noise.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if (n % 16 == 0) rb = ra;
      wide = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      rd   = wide[W-1:0];
      rbo  = wide[W];
      rov  = (ra[W-1] ^ rb[W-1]) & (ra[W-1] ^ rd[W-1]);
      start_op(ra, rb, rbin);
      wait_result(lat);
      chk("rand_latency", lat, 32'd8);
      check_res("rand", rd, rbo, (rd == '0), rov);
      guard = 0;
      while (out_valid && guard < 40) begin
        out_ready = 1'($urandom);
        in_valid  = 1'($urandom);
        a = W'($urandom); b = W'($urandom);
        tick();
        guard++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("rand_handoff", {31'b0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  operands a, b, bin presented.
REQ-005 SHALL have port: in_ready  output  1  block idle, will accept operands.
REQ-006 SHALL have port: a  input  WIDTH  minuend.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: out_valid  output  1  result registers hold a completed result.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port: bout  output  1  unsigned borrow-out (a < b + bin).
REQ-013 SHALL have port: zero  output  1  diff == 0.
REQ-014 SHALL have port: ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE), combinational from state.
REQ-016 SHALL, in IDLE on in_valid && in_ready, latch a, b into right-shift registers, bin into borrow flop, a[WIDTH-1] and b[WIDTH-1] into sign flops, clear bit counter, enter SHIFT.
REQ-017 SHALL, each SHIFT cycle, compute LSB full-subtract: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br); shift d into MSB of internal diff shift register; shift a, b right by one; increment counter.
REQ-018 SHALL spend exactly WIDTH cycles in SHIFT; on the cycle counter == WIDTH-1, transition to DONE.
REQ-019 SHALL, on SHIFT->DONE edge, load diff, bout (final borrow), zero, ovf = (a_sign ^ b_sign) & (a_sign ^ diff[WIDTH-1]) into output registers and set out_valid; out_valid rises exactly WIDTH clock edges after the accepting edge.
REQ-020 SHALL hold diff, bout, zero, ovf, out_valid stable in DONE while out_ready is low (unlimited backpressure).
REQ-021 SHALL, in DONE on out_ready high, clear out_valid and return to IDLE on that edge; diff/bout/zero/ovf retain last result until next SHIFT->DONE load.
REQ-022 SHALL ignore in_valid in SHIFT and DONE (no queuing, no operand overwrite); a, b, bin need be valid only on the accepting edge.
REQ-023 SHALL ignore out_ready when out_valid is low.
REQ-024 SHALL give minimum throughput of one result per WIDTH+2 cycles (accept, WIDTH shifts, handoff).
REQ-025 SHALL treat bin = 1 with a = b = 0 as wrap-around: diff all-ones, bout 1.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, out_valid 0, diff 0, bout 0, zero 0, ovf 0, counter 0, shift registers 0; in_ready therefore reads 1.
REQ-027 SHALL, on reset mid-SHIFT or mid-DONE, discard the operation with no partial result visible; first operation after reset release behaves per REQ-016..021.

Structure
REQ-028 SHALL place WIDTH default, counter width $clog2(WIDTH), and FSM state encoding in shared package serial_arith_pkg, for reuse by a future serial adder.
REQ-029 SHALL instantiate one combinational sub-module full_subtractor (a, b, bin -> d, bout) for the per-bit datapath of REQ-017.

Verification
REQ-030 SHALL test a=8'h05, b=8'h03, bin=0 -> diff 8'h02, bout 0, zero 0, ovf 0, out_valid exactly 8 edges after accept.
REQ-031 SHALL test a=8'h03, b=8'h05, bin=0 -> diff 8'hFE, bout 1, ovf 0; a=8'h80, b=8'h01 -> diff 8'h7F, bout 0, ovf 1.
REQ-032 SHALL test a=8'h10, b=8'h0F, bin=1 -> diff 8'h00, zero 1, bout 0; a=b=8'h00, bin=1 -> diff 8'hFF, bout 1.
REQ-033 SHALL test out_ready low 5 cycles in DONE while in_valid toggles with new operands -> outputs stable, in_ready 0, new operands not taken; next accept only after handoff.
REQ-034 SHALL test rst_n pulsed low on 4th SHIFT cycle -> immediate IDLE, out_valid 0, outputs 0; following op 8'h05-8'h03 gives 8'h02.
REQ-035 SHALL test 1000 random back-to-back ops with random out_ready against reference model (a - b - bin), checking all four result outputs.
